uart_tx_fsm: RTL and testbench

UART transmitter: serializes one 8-bit byte into an asynchronous frame (start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits) on a single output line. It is the transmit-side counterpart of the UART Rx FSM and uses the same line convention: idle high, start bit 0. The baud divider is internal, so no oversampling tick is needed. A host logic block drives it through a start/busy/done handshake.

---
 rtl/uart_tx_fsm.sv | 178 +++++++++++++++++
 tb/tb_uart_tx_fsm.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fsm.sv
// uart_tx_fsm
//   UART transmitter. Sends one byte per frame: a start bit, 8 data bits
//   LSB first, an optional parity bit, then 1 or 2 stop bits. The line
//   idles high and the start bit is 0. The baud timing comes from an
//   internal counter, so no external tick is needed.
//
// Parameters
//   CLKS_PER_BIT  clock cycles per bit period (2..65535)
//   PARITY_EN     1 inserts a parity bit after data bit 7
//   PARITY_ODD    0 = even parity, 1 = odd parity (used only with PARITY_EN)
//   STOP_BITS     number of stop bits, 1 or 2
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   i_tx_start  send request, sampled only in IDLE
//   i_tx_data   byte to send, captured on the accepting edge
//   o_tx_d      serial line (registered)
//   o_tx_busy   high in every state except IDLE (registered)
//   o_tx_done   one-cycle pulse at the end of the frame (registered)
//
// State table
//   state  | meaning
//   IDLE   | line high, waiting for i_tx_start
//   START  | driving the start bit (0)
//   DATA   | driving data bits 0..7 from the shift register
//   PARITY | driving the parity bit of the captured byte
//   STOP   | driving the stop bit(s) (1)
//   DONE   | single cycle, done pulse asserted, then back to IDLE

module uart_tx_fsm #(
  parameter int CLKS_PER_BIT = 434,
  parameter bit PARITY_EN    = 1'b0,
  parameter bit PARITY_ODD   = 1'b0,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_tx_start,
  input  logic [7:0] i_tx_data,
  output logic       o_tx_d,
  output logic       o_tx_busy,
  output logic       o_tx_done
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    DONE   = 3'd5
  } state_t;

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [1:0]  STOP_LAST = 2'(STOP_BITS - 1);

  state_t      state;
  logic [15:0] baud_cnt;
  logic [2:0]  bit_cnt;
  logic [1:0]  stop_cnt;
  logic [7:0]  shift;
  logic [7:0]  data_lat;

  logic bit_end;
  logic parity_bit;

  assign bit_end    = (baud_cnt == BAUD_LAST);
  // Parity comes from the byte as captured; the shift register has been
  // emptied by the time the parity bit goes out.
  assign parity_bit = (^data_lat) ^ PARITY_ODD;

  // Outputs are assigned together with the next state, so each output
  // register already holds the value belonging to the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      baud_cnt  <= 16'd0;
      bit_cnt   <= 3'd0;
      stop_cnt  <= 2'd0;
      shift     <= 8'd0;
      data_lat  <= 8'd0;
      o_tx_d    <= 1'b1;
      o_tx_busy <= 1'b0;
      o_tx_done <= 1'b0;
    end else begin
      o_tx_done <= 1'b0;
      case (state)
        IDLE: begin
          baud_cnt  <= 16'd0;
          o_tx_d    <= 1'b1;
          o_tx_busy <= 1'b0;
          if (i_tx_start) begin
            shift     <= i_tx_data;
            data_lat  <= i_tx_data;
            state     <= START;
            o_tx_d    <= 1'b0;
            o_tx_busy <= 1'b1;
          end
        end

        START: begin
          if (bit_end) begin
            baud_cnt <= 16'd0;
            bit_cnt  <= 3'd0;
            state    <= DATA;
            o_tx_d   <= shift[0];
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end

        DATA: begin
          if (bit_end) begin
            baud_cnt <= 16'd0;
            shift    <= {1'b0, shift[7:1]};
            bit_cnt  <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              stop_cnt <= 2'd0;
              if (PARITY_EN) begin
                state  <= PARITY;
                o_tx_d <= parity_bit;
              end else begin
                state  <= STOP;
                o_tx_d <= 1'b1;
              end
            end else begin
              // shift[1] is the bit that lands in shift[0] on this edge
              o_tx_d <= shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end

        PARITY: begin
          if (bit_end) begin
            baud_cnt <= 16'd0;
            stop_cnt <= 2'd0;
            state    <= STOP;
            o_tx_d   <= 1'b1;
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end

        STOP: begin
          if (bit_end) begin
            baud_cnt <= 16'd0;
            if (stop_cnt == STOP_LAST) begin
              state     <= DONE;
              o_tx_done <= 1'b1;
            end else begin
              stop_cnt <= stop_cnt + 2'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end

        DONE: begin
          baud_cnt  <= 16'd0;
          state     <= IDLE;
          o_tx_d    <= 1'b1;
          o_tx_busy <= 1'b0;
        end

        default: begin
          baud_cnt  <= 16'd0;
          state     <= IDLE;
          o_tx_d    <= 1'b1;
          o_tx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fsm.sv
// tb_uart_tx_fsm
//   Four transmitters at CLKS_PER_BIT=4 with different frame options:
//     0: no parity, 1 stop   1: even parity, 1 stop
//     2: odd parity, 1 stop  3: no parity, 2 stops
//   The expected line is built as a list of frame bits from the byte and
//   options, and each cycle's value is that list indexed by elapsed time.

module tb_uart_tx_fsm;

  localparam int       CPB   = 4;
  localparam bit [3:0] P_EN  = 4'b0110;
  localparam bit [3:0] P_ODD = 4'b0100;
  localparam bit [3:0] STOP2 = 4'b1000;

  logic       clk;
  logic       rst_n;
  logic [3:0] start;
  logic [7:0] tx_data;
  logic [3:0] tx_d;
  logic [3:0] busy;
  logic [3:0] done;

  int n_checks = 0;
  int n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  uart_tx_fsm #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b0), .PARITY_ODD(1'b0), .STOP_BITS(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .i_tx_start(start[0]), .i_tx_data(tx_data),
    .o_tx_d(tx_d[0]), .o_tx_busy(busy[0]), .o_tx_done(done[0]));

  uart_tx_fsm #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1), .PARITY_ODD(1'b0), .STOP_BITS(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .i_tx_start(start[1]), .i_tx_data(tx_data),
    .o_tx_d(tx_d[1]), .o_tx_busy(busy[1]), .o_tx_done(done[1]));

  uart_tx_fsm #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1), .PARITY_ODD(1'b1), .STOP_BITS(1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .i_tx_start(start[2]), .i_tx_data(tx_data),
    .o_tx_d(tx_d[2]), .o_tx_busy(busy[2]), .o_tx_done(done[2]));

  uart_tx_fsm #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b0), .PARITY_ODD(1'b0), .STOP_BITS(2)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .i_tx_start(start[3]), .i_tx_data(tx_data),
    .o_tx_d(tx_d[3]), .o_tx_busy(busy[3]), .o_tx_done(done[3]));

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (time %0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_line(input int idx, input string tag, input logic ed, input logic eb,
                            input logic edn);
    check_val($sformatf("%s dut%0d tx_d", tag, idx), 32'(tx_d[idx]), 32'(ed));
    check_val($sformatf("%s dut%0d busy", tag, idx), 32'(busy[idx]), 32'(eb));
    check_val($sformatf("%s dut%0d done", tag, idx), 32'(done[idx]), 32'(edn));
  endtask

  // Line must stay idle for n cycles (no queued or spurious frame).
  task automatic idle_check(input int idx, input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      check_line(idx, "idle", 1'b1, 1'b0, 1'b0);
    end
  endtask

  // Sends byte b on dut idx and checks every cycle from the accept edge
  // through the cycle where busy has dropped. pulse_at (>0) re-raises start
  // with a different byte on that frame cycle; hold keeps start high so the
  // next call's accept edge is the first one seen in IDLE.
  task automatic run_frame(input int idx, input logic [7:0] b, input bit hold,
                           input int pulse_at);
    bit exp_bits[$];
    int n;
    exp_bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_bits.push_back(b[i]);
    if (P_EN[idx]) exp_bits.push_back((($countones(b) % 2) == 1) ^ P_ODD[idx]);
    exp_bits.push_back(1'b1);
    if (STOP2[idx]) exp_bits.push_back(1'b1);
    n = exp_bits.size() * CPB;

    @(negedge clk);
    tx_data    = b;
    start[idx] = 1'b1;
    @(posedge clk);
    for (int t = 1; t <= n + 2; t++) begin
      #1;
      if (t <= n)
        check_line(idx, $sformatf("frame b=%02h t=%0d", b, t), exp_bits[(t - 1) / CPB], 1'b1, 1'b0);
      else if (t == n + 1)
        check_line(idx, $sformatf("done b=%02h", b), 1'b1, 1'b1, 1'b1);
      else
        check_line(idx, $sformatf("end b=%02h", b), 1'b1, 1'b0, 1'b0);
      if (t < n + 2) begin
        @(negedge clk);
        tx_data = 8'($urandom);
        if (t == pulse_at) begin
          start[idx] = 1'b1;
          tx_data    = 8'h3C;
        end else if (!hold) begin
          start[idx] = 1'b0;
        end
        @(posedge clk);
      end else if (!hold) begin
        start[idx] = 1'b0;
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    int pulse;
    logic [7:0] b;

    rst_n   = 1'b0;
    start   = 4'b0000;
    tx_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) check_line(i, "reset", 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    idle_check(0, 2);

    // Directed frames from the test plan
    run_frame(0, 8'hA5, 1'b0, 0);
    idle_check(0, 2);
    run_frame(1, 8'hA5, 1'b0, 0);
    idle_check(1, 2);
    run_frame(2, 8'hA5, 1'b0, 0);
    idle_check(2, 2);
    run_frame(3, 8'h00, 1'b0, 0);
    idle_check(3, 2);

    // Start pulse mid-frame and during DONE must be ignored
    run_frame(0, 8'hFF, 1'b0, 17);
    idle_check(0, 4);
    run_frame(0, 8'hFF, 1'b0, 41);
    idle_check(0, 4);

    // Held start: back-to-back frames with period N+2
    run_frame(0, 8'h55, 1'b1, 0);
    run_frame(0, 8'h55, 1'b0, 0);
    idle_check(0, 3);

    // Reset during data bit 3 (0x62 has bit 3 = 0, so the line is low there)
    @(negedge clk);
    tx_data  = 8'h62;
    start[0] = 1'b1;
    @(posedge clk);
    #1;
    start[0] = 1'b0;
    repeat (17) @(posedge clk);
    #2;
    check_line(0, "pre-reset bit3", 1'b0, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    check_line(0, "in-reset", 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle_check(0, 5);
    run_frame(0, 8'h81, 1'b0, 0);
    idle_check(0, 2);

    // Randomized frames across all configurations
    for (int r = 0; r < 24; r++) begin
      idx   = int'($urandom_range(0, 3));
      b     = 8'($urandom);
      pulse = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 45));
      run_frame(idx, b, 1'b0, pulse);
      idle_check(idx, int'($urandom_range(1, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
